// File: rtl/riscv_hazard_ctrl.sv
// Hazard control for the 5-stage core: forwarding, load-use
// and data-memory wait stalls, redirect flushes, stall counter.
module riscv_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int PERF_W         = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [4:0]        i_regfile_rs1_addrD,
  input  logic [4:0]        i_regfile_rs2_addrD,
  input  logic [4:0]        i_regfile_rs1_addrE,
  input  logic [4:0]        i_regfile_rs2_addrE,
  input  logic [4:0]        i_regfile_rd_addrE,
  input  logic [1:0]        i_ctrl_result_srcE,
  input  logic [1:0]        i_PCSrcE,
  input  logic [4:0]        i_regfile_rd_addrM,
  input  logic              i_ctrl_reg_wr_enM,
  input  logic [4:0]        i_regfile_rd_addrW,
  input  logic              i_ctrl_reg_wr_enW,
  input  logic              i_mem_reqM,
  input  logic              i_dmem_ready,
  output logic [1:0]        o_hazard_forwardAE,
  output logic [1:0]        o_hazard_forwardBE,
  output logic              o_hazard_stallF,
  output logic              o_hazard_stallD,
  output logic              o_hazard_stallE,
  output logic              o_hazard_flushD,
  output logic              o_hazard_flushE,
  output logic              o_dmem_timeout,
  output logic [PERF_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RELEASE
  } state_t;

  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT_CYCLES);

  state_t     state;
  logic [7:0] waitCnt;
  logic [8:0] nextCnt;
  logic       matchAM;
  logic       matchAW;
  logic       matchBM;
  logic       matchBW;
  logic       loadStall;
  logic       memStall;
  logic       redirect;

  // Operand source matches against the M and W destinations
  always_comb begin
    matchAM = i_ctrl_reg_wr_enM
            && (i_regfile_rd_addrM != 5'd0)
            && (i_regfile_rd_addrM == i_regfile_rs1_addrE);
    matchAW = i_ctrl_reg_wr_enW
            && (i_regfile_rd_addrW != 5'd0)
            && (i_regfile_rd_addrW == i_regfile_rs1_addrE);
    matchBM = i_ctrl_reg_wr_enM
            && (i_regfile_rd_addrM != 5'd0)
            && (i_regfile_rd_addrM == i_regfile_rs2_addrE);
    matchBW = i_ctrl_reg_wr_enW
            && (i_regfile_rd_addrW != 5'd0)
            && (i_regfile_rd_addrW == i_regfile_rs2_addrE);
  end

  // Forward select for operand A, youngest producer wins
  always_comb begin
    o_hazard_forwardAE = 2'b00;
    priority case (1'b1)
      matchAM: o_hazard_forwardAE = 2'b10;
      matchAW: o_hazard_forwardAE = 2'b01;
      default: o_hazard_forwardAE = 2'b00;
    endcase
  end

  // Forward select for operand B, youngest producer wins
  always_comb begin
    o_hazard_forwardBE = 2'b00;
    priority case (1'b1)
      matchBM: o_hazard_forwardBE = 2'b10;
      matchBW: o_hazard_forwardBE = 2'b01;
      default: o_hazard_forwardBE = 2'b00;
    endcase
  end

  // Stall and flush decisions; a memory wait freezes the redirect
  always_comb begin
    loadStall = (i_ctrl_result_srcE == 2'b01)
              && (i_regfile_rd_addrE != 5'd0)
              && ((i_regfile_rd_addrE == i_regfile_rs1_addrD)
               || (i_regfile_rd_addrE == i_regfile_rs2_addrD));
    memStall  = i_mem_reqM && !i_dmem_ready
              && (state != S_RELEASE);
    redirect  = (i_PCSrcE != 2'b00);
    nextCnt   = {1'b0, waitCnt} + 9'd1;
    o_hazard_stallF = loadStall || memStall;
    o_hazard_stallD = loadStall || memStall;
    o_hazard_stallE = memStall;
    o_hazard_flushD = !memStall && redirect;
    o_hazard_flushE = !memStall && (loadStall || redirect);
  end

  // Memory wait tracker with forced one-cycle release on timeout
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state          <= S_IDLE;
      waitCnt        <= 8'd0;
      o_dmem_timeout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (memStall) begin
            waitCnt <= 8'd1;
            if (TimeoutLim <= 9'd1) begin
              state          <= S_RELEASE;
              o_dmem_timeout <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!memStall) begin
            state   <= S_IDLE;
            waitCnt <= 8'd0;
          end else begin
            waitCnt <= nextCnt[7:0];
            if (nextCnt >= TimeoutLim) begin
              state          <= S_RELEASE;
              o_dmem_timeout <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
          state   <= S_IDLE;
          waitCnt <= 8'd0;
        end
        default: begin
          state   <= S_IDLE;
          waitCnt <= 8'd0;
        end
      endcase
    end
  end

  // Saturating count of front-end stall cycles
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stall_cnt <= '0;
    end else if (o_hazard_stallF && !(&o_stall_cnt)) begin
      o_stall_cnt <= o_stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Bench for riscv_hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_riscv_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0] srcE, pcE;
  logic       wrM, wrW, req, rdy;

  logic [1:0]  fa, fb, fa2, fb2;
  logic        sF, sD, sE, fD, fE, to;
  logic        sF2, sD2, sE2, fD2, fE2, to2;
  logic [31:0] cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int failures = 0;

  int     mRun;
  bit     mRel, mTo;
  longint mCnt;
  int     mCnt4;

  always #5 clk = ~clk;

  riscv_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .PERF_W(32)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_regfile_rs1_addrD(rs1D), .i_regfile_rs2_addrD(rs2D),
    .i_regfile_rs1_addrE(rs1E), .i_regfile_rs2_addrE(rs2E),
    .i_regfile_rd_addrE(rdE), .i_ctrl_result_srcE(srcE),
    .i_PCSrcE(pcE),
    .i_regfile_rd_addrM(rdM), .i_ctrl_reg_wr_enM(wrM),
    .i_regfile_rd_addrW(rdW), .i_ctrl_reg_wr_enW(wrW),
    .i_mem_reqM(req), .i_dmem_ready(rdy),
    .o_hazard_forwardAE(fa), .o_hazard_forwardBE(fb),
    .o_hazard_stallF(sF), .o_hazard_stallD(sD),
    .o_hazard_stallE(sE),
    .o_hazard_flushD(fD), .o_hazard_flushE(fE),
    .o_dmem_timeout(to), .o_stall_cnt(cnt)
  );

  riscv_hazard_ctrl #(.TIMEOUT_CYCLES(TO), .PERF_W(4)) dut4 (
    .i_clk(clk), .i_rstn(rstn),
    .i_regfile_rs1_addrD(rs1D), .i_regfile_rs2_addrD(rs2D),
    .i_regfile_rs1_addrE(rs1E), .i_regfile_rs2_addrE(rs2E),
    .i_regfile_rd_addrE(rdE), .i_ctrl_result_srcE(srcE),
    .i_PCSrcE(pcE),
    .i_regfile_rd_addrM(rdM), .i_ctrl_reg_wr_enM(wrM),
    .i_regfile_rd_addrW(rdW), .i_ctrl_reg_wr_enW(wrW),
    .i_mem_reqM(req), .i_dmem_ready(rdy),
    .o_hazard_forwardAE(fa2), .o_hazard_forwardBE(fb2),
    .o_hazard_stallF(sF2), .o_hazard_stallD(sD2),
    .o_hazard_stallE(sE2),
    .o_hazard_flushD(fD2), .o_hazard_flushE(fE2),
    .o_dmem_timeout(to2), .o_stall_cnt(cnt4)
  );

  function automatic logic [1:0] fwdRef(logic [4:0] rs);
    if (wrM && rdM != 0 && rdM == rs) return 2'b10;
    if (wrW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit loadRef();
    return srcE == 2'b01 && rdE != 0
        && (rdE == rs1D || rdE == rs2D);
  endfunction

  function automatic bit memRef();
    return req && !rdy && !mRel;
  endfunction

  function automatic logic [55:0] expVec();
    logic [9:0] b;
    bit ld, mem, red;
    ld  = loadRef();
    mem = memRef();
    red = pcE != 2'b00;
    b = {fwdRef(rs1E), fwdRef(rs2E), ld || mem, ld || mem, mem,
         !mem && red, !mem && (ld || red), mTo};
    return {b, 32'(mCnt), b, 4'(mCnt4)};
  endfunction

  function automatic logic [55:0] gotVec();
    return {fa, fb, sF, sD, sE, fD, fE, to, cnt,
            fa2, fb2, sF2, sD2, sE2, fD2, fE2, to2, cnt4};
  endfunction

  task automatic clearModel();
    mRun = 0; mRel = 0; mTo = 0; mCnt = 0; mCnt4 = 0;
  endtask

  task automatic setRst(bit v);
    rstn = v;
    if (!v) clearModel();
  endtask

  task automatic clearIn();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0;
    rdM = 0; rdW = 0; srcE = 0; pcE = 0;
    wrM = 0; wrW = 0; req = 0; rdy = 0;
  endtask

  // advance one clock and update the reference model
  task automatic tick();
    bit stall, mem;
    mem   = memRef();
    stall = mem || loadRef();
    @(posedge clk);
    #1;
    if (!rstn) begin
      clearModel();
    end else begin
      if (stall) begin
        mCnt  = mCnt + 1;
        mCnt4 = (mCnt4 < 15) ? mCnt4 + 1 : 15;
      end
      if (mRel) begin
        mRel = 0; mRun = 0;
      end else if (mem) begin
        mRun++;
        if (mRun >= TO) begin mRel = 1; mTo = 1; end
      end else begin
        mRun = 0;
      end
    end
  endtask

  task automatic test_reset();
    clearIn();
    setRst(0);
    rdM = 5; wrM = 1; rs1E = 5;
    @(negedge clk);
    checks++;
    if (cnt !== 32'd0 || to !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs cnt=%0d to=%b need 0 0", cnt, to);
    end
    checks++;
    if (fa !== 2'b10) begin
      failures++;
      $display("FAIL reset_fwd got=%b need 10", fa);
    end
    tick();
    setRst(1);
    clearIn();
  endtask

  task automatic test_forward();
    logic [1:0] need [3];
    need[0] = 2'b10; need[1] = 2'b01; need[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      clearIn();
      rs1E = 5; wrM = (i != 1); wrW = 1;
      rdM = (i == 2) ? 5'd0 : 5'd5;
      rdW = (i == 2) ? 5'd0 : 5'd5;
      @(negedge clk);
      checks++;
      if (fa !== need[i]) begin
        failures++;
        $display("FAIL fwd_dir%0d got=%b need=%b", i, fa, need[i]);
      end
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      clearIn();
      rs1E = 5'($urandom_range(0, 3));
      rs2E = 5'($urandom_range(0, 3));
      rdM  = 5'($urandom_range(0, 3));
      rdW  = 5'($urandom_range(0, 3));
      wrM  = 1'($urandom); wrW = 1'($urandom);
      @(negedge clk);
      checks++;
      if (gotVec() !== expVec()) begin
        failures++;
        $display("FAIL fwd_rand got=%h need=%h",
                 gotVec(), expVec());
      end
      tick();
    end
  endtask

  task automatic test_load_stall();
    longint c0;
    clearIn();
    srcE = 2'b01; rdE = 3; rs2D = 3;
    c0 = mCnt;
    @(negedge clk);
    checks++;
    if ({sF, sD, sE, fD, fE} !== 5'b11001) begin
      failures++;
      $display("FAIL load_stall got=%b need=11001",
               {sF, sD, sE, fD, fE});
    end
    tick();
    clearIn();
    @(negedge clk);
    checks++;
    if (cnt !== 32'(c0 + 1) || sF !== 1'b0) begin
      failures++;
      $display("FAIL load_cnt cnt=%0d sF=%b need %0d 0",
               cnt, sF, c0 + 1);
    end
    tick();
  endtask

  task automatic test_redirect();
    clearIn();
    pcE = 2'b01;
    @(negedge clk);
    checks++;
    if ({sF, sD, sE, fD, fE} !== 5'b00011) begin
      failures++;
      $display("FAIL redirect got=%b need=00011",
               {sF, sD, sE, fD, fE});
    end
    tick();
  endtask

  task automatic test_mem_stall();
    logic [4:0] need;
    clearIn();
    req = 1; pcE = 2'b10;
    for (int i = 0; i < 4; i++) begin
      rdy  = (i == 3);
      need = (i == 3) ? 5'b00011 : 5'b11100;
      @(negedge clk);
      checks++;
      if ({sF, sD, sE, fD, fE} !== need) begin
        failures++;
        $display("FAIL mem_stall c%0d got=%b need=%b",
                 i, {sF, sD, sE, fD, fE}, need);
      end
      tick();
    end
    clearIn();
  endtask

  task automatic test_timeout();
    logic [5:0] need;
    clearIn();
    req = 1;
    for (int i = 0; i < 6; i++) begin
      need = (i < 4) ? 6'b111000
           : (i == 4) ? 6'b000001 : 6'b111001;
      @(negedge clk);
      checks++;
      if ({sF, sD, sE, fD, fE, to} !== need) begin
        failures++;
        $display("FAIL timeout c%0d got=%b need=%b",
                 i, {sF, sD, sE, fD, fE, to}, need);
      end
      tick();
    end
    clearIn();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (to !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got=%b need=1", to);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    clearIn();
    req = 1;
    tick();
    tick();
    setRst(0);
    @(negedge clk);
    checks++;
    if ({cnt, to, sF} !== {32'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL rst_wait cnt=%0d to=%b sF=%b need 0 0 1",
               cnt, to, sF);
    end
    tick();
    setRst(1);
    clearIn();
    @(negedge clk);
    checks++;
    if (sF !== 1'b0 || cnt !== 32'd0) begin
      failures++;
      $display("FAIL rst_wait_after sF=%b cnt=%0d need 0 0",
               sF, cnt);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!rstn) setRst(1);
      else if ($urandom_range(0, 99) == 0) setRst(0);
      rs1D = 5'($urandom_range(0, 7));
      rs2D = 5'($urandom_range(0, 7));
      rs1E = 5'($urandom_range(0, 7));
      rs2E = 5'($urandom_range(0, 7));
      rdE  = 5'($urandom_range(0, 7));
      rdM  = 5'($urandom_range(0, 7));
      rdW  = 5'($urandom_range(0, 7));
      srcE = 2'($urandom);
      pcE  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      wrM  = 1'($urandom); wrW = 1'($urandom);
      req  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      rdy  = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      checks++;
      if (gotVec() !== expVec()) begin
        failures++;
        $display("FAIL rand c%0d got=%h need=%h",
                 i, gotVec(), expVec());
      end
      tick();
    end
  endtask

  initial begin
    clearModel();
    test_reset();
    test_forward();
    test_load_stall();
    test_redirect();
    test_mem_stall();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
